// File: rtl/decompose_l6.sv
// decompose_l6: level-6 sym4 analysis stage. Filters the a5 stream with the
// 8-tap low/high decomposition filters and decimates by 2 into a6/d6 pairs.
// Ports:
//   clk, rst (sync, active-high)
//   din_valid, a5_in      : input sample stream, accepted whenever din_valid=1
//   dout_valid            : one-cycle pulse, a6_out/d6_out carry a new pair
//   a6_out, d6_out        : approximation/detail coefficients, held between pulses
//   settled               : 8 samples accepted since reset (window free of reset zeros)
module decompose_l6 #(
    parameter int INTERNAL_WIDTH = 48,
    parameter int COEF_WIDTH     = 25,
    parameter int COEF_FRAC      = 23,
    parameter logic signed [COEF_WIDTH-1:0] DEC_LO0 = '0,
    parameter logic signed [COEF_WIDTH-1:0] DEC_LO1 = '0,
    parameter logic signed [COEF_WIDTH-1:0] DEC_LO2 = '0,
    parameter logic signed [COEF_WIDTH-1:0] DEC_LO3 = '0,
    parameter logic signed [COEF_WIDTH-1:0] DEC_LO4 = '0,
    parameter logic signed [COEF_WIDTH-1:0] DEC_LO5 = '0,
    parameter logic signed [COEF_WIDTH-1:0] DEC_LO6 = '0,
    parameter logic signed [COEF_WIDTH-1:0] DEC_LO7 = '0,
    parameter logic signed [COEF_WIDTH-1:0] DEC_HI0 = '0,
    parameter logic signed [COEF_WIDTH-1:0] DEC_HI1 = '0,
    parameter logic signed [COEF_WIDTH-1:0] DEC_HI2 = '0,
    parameter logic signed [COEF_WIDTH-1:0] DEC_HI3 = '0,
    parameter logic signed [COEF_WIDTH-1:0] DEC_HI4 = '0,
    parameter logic signed [COEF_WIDTH-1:0] DEC_HI5 = '0,
    parameter logic signed [COEF_WIDTH-1:0] DEC_HI6 = '0,
    parameter logic signed [COEF_WIDTH-1:0] DEC_HI7 = '0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             din_valid,
    input  logic signed [INTERNAL_WIDTH-1:0] a5_in,
    output logic                             dout_valid,
    output logic signed [INTERNAL_WIDTH-1:0] a6_out,
    output logic signed [INTERNAL_WIDTH-1:0] d6_out,
    output logic                             settled
);

    localparam int PW = INTERNAL_WIDTH + COEF_WIDTH;
    localparam int SW = PW + 3;

    localparam logic signed [COEF_WIDTH-1:0] LO [8] = '{
        DEC_LO0, DEC_LO1, DEC_LO2, DEC_LO3,
        DEC_LO4, DEC_LO5, DEC_LO6, DEC_LO7
    };
    localparam logic signed [COEF_WIDTH-1:0] HI [8] = '{
        DEC_HI0, DEC_HI1, DEC_HI2, DEC_HI3,
        DEC_HI4, DEC_HI5, DEC_HI6, DEC_HI7
    };

    logic signed [INTERNAL_WIDTH-1:0] tap [8];
    logic                             ph;
    logic [3:0]                       cnt;
    logic                             v1, v2, v3;
    logic signed [PW-1:0]             prod_lo [8];
    logic signed [PW-1:0]             prod_hi [8];
    logic signed [SW-1:0]             acc_lo, acc_hi;
    logic signed [SW-1:0]             sum_lo, sum_hi;

    // Floor shift by COEF_FRAC, keeping only the low INTERNAL_WIDTH bits.
    function automatic logic signed [INTERNAL_WIDTH-1:0] scale(
        input logic signed [SW-1:0] s
    );
        return s[COEF_FRAC+INTERNAL_WIDTH-1:COEF_FRAC];
    endfunction

    // Tap line, pair phase and sample counter. A sample arriving while
    // ph==1 completes a pair and launches a computation (v1).
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 8; k++) tap[k] <= '0;
            ph  <= 1'b0;
            cnt <= 4'd0;
            v1  <= 1'b0;
        end else begin
            v1 <= din_valid & ph;
            if (din_valid) begin
                tap[0] <= a5_in;
                for (int k = 1; k < 8; k++) tap[k] <= tap[k-1];
                ph <= ~ph;
                if (cnt != 4'd8) cnt <= cnt + 4'd1;
            end
        end
    end

    assign settled = (cnt == 4'd8);

    // Pipeline valids: taps -> products -> sums -> outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            v2 <= 1'b0;
            v3 <= 1'b0;
        end else begin
            v2 <= v1;
            v3 <= v2;
        end
    end

    // Full-precision products; data path runs every cycle.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 8; k++) begin
            prod_lo[k] <= PW'(tap[k]) * PW'(LO[k]);
            prod_hi[k] <= PW'(tap[k]) * PW'(HI[k]);
        end
    end

    // Three guard bits cover the growth of an 8-term sum.
    always_comb begin
        acc_lo = '0;
        acc_hi = '0;
        for (int k = 0; k < 8; k++) begin
            acc_lo = acc_lo + SW'(prod_lo[k]);
            acc_hi = acc_hi + SW'(prod_hi[k]);
        end
    end

    always_ff @(posedge clk) begin
        sum_lo <= acc_lo;
        sum_hi <= acc_hi;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_valid <= 1'b0;
            a6_out     <= '0;
            d6_out     <= '0;
        end else begin
            dout_valid <= v3;
            if (v3) begin
                a6_out <= scale(sum_lo);
                d6_out <= scale(sum_hi);
            end
        end
    end

endmodule

// File: tb/tb_decompose_l6.sv
// tb_decompose_l6: scoreboard bench for decompose_l6 using three instances
// (identity taps, half-gain low-pass, 2^-23 low-pass) driven from directed vectors.
module tb_decompose_l6;

    typedef struct {
        int                 cyc;
        logic signed [47:0] a;
        logic signed [47:0] d;
    } exp_t;

    logic               clk;
    logic               rst;
    logic [2:0]         din_valid;
    logic signed [47:0] a5 [3];
    logic [2:0]         dv_o;
    logic signed [47:0] a6 [3];
    logic signed [47:0] d6 [3];
    logic [2:0]         settled;

    int   edges = 0;
    int   npass = 0;
    int   ntot  = 0;
    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    decompose_l6 #(
        .DEC_LO0(25'sd8388608),
        .DEC_HI1(-25'sd8388608)
    ) u_id (
        .clk(clk), .rst(rst),
        .din_valid(din_valid[0]), .a5_in(a5[0]),
        .dout_valid(dv_o[0]), .a6_out(a6[0]), .d6_out(d6[0]),
        .settled(settled[0])
    );

    decompose_l6 #(
        .DEC_LO0(25'sd4194304), .DEC_LO1(25'sd4194304),
        .DEC_LO2(25'sd4194304), .DEC_LO3(25'sd4194304),
        .DEC_LO4(25'sd4194304), .DEC_LO5(25'sd4194304),
        .DEC_LO6(25'sd4194304), .DEC_LO7(25'sd4194304)
    ) u_half (
        .clk(clk), .rst(rst),
        .din_valid(din_valid[1]), .a5_in(a5[1]),
        .dout_valid(dv_o[1]), .a6_out(a6[1]), .d6_out(d6[1]),
        .settled(settled[1])
    );

    decompose_l6 #(
        .DEC_LO0(25'sd1)
    ) u_tr (
        .clk(clk), .rst(rst),
        .din_valid(din_valid[2]), .a5_in(a5[2]),
        .dout_valid(dv_o[2]), .a6_out(a6[2]), .d6_out(d6[2]),
        .settled(settled[2])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) edges <= edges + 1;

    task automatic check(string name, longint got, longint exp);
        ntot++;
        if (got == exp) npass++;
        else $display("FAIL %s: got %0d, required %0d", name, got, exp);
    endtask

    // Monitor: pops the expected pair whenever an instance pulses dout_valid.
    always @(negedge clk) begin
        exp_t e;
        bit   ok;
        for (int i = 0; i < 3; i++) begin
            if (dv_o[i] === 1'b1) begin
                ok = 1'b1;
                case (i)
                    0: if (q0.size() > 0) e = q0.pop_front(); else ok = 1'b0;
                    1: if (q1.size() > 0) e = q1.pop_front(); else ok = 1'b0;
                    default: if (q2.size() > 0) e = q2.pop_front(); else ok = 1'b0;
                endcase
                if (!ok) begin
                    ntot++;
                    $display("FAIL unexpected_pulse inst%0d cycle %0d: a6=%0d d6=%0d, required no pulse",
                             i, edges, a6[i], d6[i]);
                end else begin
                    check($sformatf("inst%0d_cycle", i), edges, e.cyc);
                    check($sformatf("inst%0d_a6", i), a6[i], e.a);
                    check($sformatf("inst%0d_d6", i), d6[i], e.d);
                end
            end
        end
    end

    task automatic send(int i, longint v, bit chk, longint ea, longint ed);
        int   cur;
        exp_t e;
        @(negedge clk);
        din_valid[i] = 1'b1;
        a5[i] = v[47:0];
        cur = edges;
        if (chk) begin
            e.cyc = cur + 4;
            e.a = ea[47:0];
            e.d = ed[47:0];
            case (i)
                0: q0.push_back(e);
                1: q1.push_back(e);
                default: q2.push_back(e);
            endcase
        end
        @(posedge clk);
        #1;
        din_valid[i] = 1'b0;
    endtask

    task automatic gap(int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        din_valid = 3'b111;
        for (int i = 0; i < 3; i++) a5[i] = 48'sh5;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_dout_valid", dv_o[0], 0);
        check("rst_a6", a6[0], 0);
        check("rst_d6", d6[0], 0);
        check("rst_settled", settled[0], 0);
        rst = 1'b0;
        din_valid = 3'b000;

        // Identity taps, one sample every 2 cycles
        send(0, 10, 0, 0, 0);   gap(1);
        send(0, 20, 1, 20, -10); gap(1);
        send(0, 30, 0, 0, 0);   gap(1);
        send(0, 40, 1, 40, -30);
        gap(8);
        do_reset();

        // Back-to-back samples 1..8
        for (int k = 1; k <= 8; k++) begin
            send(0, k, (k % 2) == 0, k, -(k - 1));
            check($sformatf("settled_after_%0d", k), settled[0], (k == 8) ? 1 : 0);
        end
        gap(8);

        // Half-gain low-pass: ramp then steady 4000
        for (int k = 1; k <= 16; k++) begin
            send(1, 1000, (k % 2) == 0, 1000 * ((k / 2 < 4) ? k / 2 : 4), 0);
        end
        gap(8);

        // Mid-stream reset two cycles after a trigger discards that result
        send(1, 1000, 0, 0, 0);
        send(1, 1000, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_settled", settled[1], 0);
        send(1, 1000, 0, 0, 0);
        send(1, 1000, 1, 1000, 0);
        gap(8);
        do_reset();

        // Truncation by floor shift
        send(2, 0, 0, 0, 0);
        send(2, -1, 1, -1, 0);
        send(2, 0, 0, 0, 0);
        send(2, (64'sd1 <<< 23) - 1, 1, 0, 0);
        gap(8);

        @(negedge clk);
        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);
        check("q2_drained", q2.size(), 0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule

// File: doc/decompose_l6.md
# decompose_L6

Sixth-level sym4 wavelet analysis stage. It takes the level-5 approximation stream a5, filters it with the 8-tap low-pass and high-pass decomposition filters, and downsamples by 2. Each output is one a6/d6 coefficient pair. It is the forward counterpart of the L6 reconstruction stage and sits between decomposition L5 and the coefficient store / reconstruct_L6. It is fully pipelined with no backpressure.

## Interface
- INTERNAL_WIDTH, 48, sample/coefficient data width (signed)
- COEF_WIDTH, 25, filter coefficient width (signed)
- COEF_FRAC, 23, fractional bits of coefficients
- DEC_LO0..DEC_LO7, 0, signed low-pass decomposition taps, COEF_WIDTH bits each
- DEC_HI0..DEC_HI7, 0, signed high-pass decomposition taps, COEF_WIDTH bits each

Ports:
- clk  in  1  sole clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- din_valid  in  1  a5_in valid this cycle; may be asserted any cycle
- a5_in  in  INTERNAL_WIDTH  signed a5 sample
- dout_valid  out  1  one-cycle pulse, a6_out/d6_out valid
- a6_out  out  INTERNAL_WIDTH  signed approximation coefficient
- d6_out  out  INTERNAL_WIDTH  signed detail coefficient
- settled  out  1  high once 8 samples have been accepted since reset; the output window then contains no reset zeros

## Operation
- Tap line tap[0..7], where tap[0] is newest. On each din_valid: tap[k] <= tap[k-1] and tap[0] <= a5_in. All taps reset to 0, so startup is zero-padded.
- Pair phase bit `ph` toggles on each accepted sample and resets to 0.
- A sample accepted while ph==1 (the 2nd, 4th, 6th… since reset) is a trigger. It launches one computation on the tap line as updated by that sample.
- Stage 1 (registered): 16 products, LO_k*tap[k] and HI_k*tap[k]. Each product is INTERNAL_WIDTH+COEF_WIDTH bits, full precision.
- Stage 2 (registered): two 8-input sums, 3 guard bits each, no overflow possible.
- Stage 3 (output register):
  - a6_out = sum_lo[COEF_FRAC+INTERNAL_WIDTH-1 : COEF_FRAC] and d6_out likewise from sum_hi.
  - This is a floor shift by COEF_FRAC, with no rounding and no saturation; upper bits are discarded.
- A valid bit travels alongside the data through all stages. dout_valid is that valid at the output register.
- a6_out and d6_out hold their last value while dout_valid=0.
- Sample counter `cnt` counts accepted samples and saturates at 8; settled = (cnt==8).
- Non-trigger samples only shift the tap line. Samples are never dropped.

## Timing
- Reset values: dout_valid=0, a6_out=0, d6_out=0, settled=0. Also cleared: tap line, ph, cnt, and all pipeline valids.
- Latency: a trigger sample with din_valid high in cycle T produces dout_valid high in cycle T+4, for exactly one cycle.
  - T+1: taps updated.
  - T+2: products registered.
  - T+3: sums registered.
  - T+4: outputs registered.
- Throughput: with din_valid every cycle, dout_valid is high every 2nd cycle. With a5 every 2 cycles (nominal), it is high every 4 cycles.
- Input gaps of any length are allowed; phase is kept by ph, not by a cycle count.
- The pipeline advances every cycle regardless of din_valid. In-flight results are always emitted, even if input stops.
- settled rises in the cycle after the 8th accepted sample's edge, i.e. registered with cnt.
- Reset mid-operation (rst high in cycle R):
  - From R+1, all state is cleared and in-flight results are discarded.
  - dout_valid is 0 from R+1 until a new trigger +4.
  - din_valid is ignored while rst=1.

## Test plan
- Reset check: assert rst for 2 cycles with din_valid=1 and a5_in=0x5. Required: dout_valid, a6_out, d6_out and settled all 0; the first post-reset sample is treated as ph==0.
- Identity taps: DEC_LO0=1<<23, DEC_HI1=-(1<<23), others 0. Feed a5 = 10,20,30,40 every 2 cycles from cycle 0. Required: dout_valid at cycles 6 and 10 with (a6,d6) = (20,-10) and (40,-30); no other pulses.
- Back-to-back input: same taps, din_valid every cycle with values 1..8. Required: pulses at cycles 5,7,9,11 with a6 = 2,4,6,8 and d6 = -1,-3,-5,-7; settled goes high after sample 8.
- Full filter: all LO taps = 0.5 (1<<22), all HI taps = 0. Feed a constant 1000 for 16 samples. Required: a6 ramps 1000,2000,3000 and then holds 4000 from the 4th output on; d6 = 0 throughout.
- Truncation: DEC_LO0=1 (2^-23), others 0. Feed samples 0,-1. Required: a6 = -1 (floor, not 0). Feed 0,(1<<23)-1. Required: a6 = 0.
- Mid-stream reset: pulse rst for 1 cycle at T+2 after a trigger. Required: no dout_valid at T+4; the next output uses zero-padded history.
